ppu_tile_shifter: RTL

PPU_TILE_SHIFTER -- requirements
Module: ppu_tile_shifter

---
 rtl/ppu_shift_pkg.sv | 14 +
 rtl/shift_lane.sv | 55 +++++
 rtl/ppu_tile_shifter.sv | 109 ++++++++++
 3 files changed

// File: rtl/ppu_shift_pkg.sv
// Shared constants for the PPU background tile shifter: default geometry and
// the role of each shift plane.
package ppu_shift_pkg;

  localparam int DEF_PLANES = 4;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_LOAD_W = 8;

  localparam int PAT_LO  = 0;
  localparam int PAT_HI  = 1;
  localparam int ATTR_LO = 2;
  localparam int ATTR_HI = 3;

endpackage

// File: rtl/shift_lane.sv
// One WIDTH-bit shift lane: serial fill into the MSB, parallel load of the
// top LOAD_W bits, and a tap select for the pixel bit.
module shift_lane #(
  parameter int WIDTH  = 16,
  parameter int LOAD_W = 8,
  parameter int OW     = $clog2(LOAD_W)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_shift,
  input  logic              i_fill,
  input  logic              i_load,
  input  logic [LOAD_W-1:0] i_load_data,
  input  logic [OW-1:0]     i_tap,
  output logic              o_tap,
  output logic [WIDTH-1:0]  o_lane
);

  localparam int TW = $clog2(WIDTH);
  // Bits below the parallel-load window keep the (possibly shifted) contents.
  localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> LOAD_W;

  logic [WIDTH-1:0] r_lane;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next;
  logic [TW-1:0]    w_tap_idx;

  always_comb begin
    w_base = r_lane;
    w_next = r_lane;
    if (i_shift) begin
      w_base = {i_fill, r_lane[WIDTH-1:1]};
    end else begin
      w_base = r_lane;
    end
    if (i_load) begin
      w_next = (w_base & LOW_MASK) | (WIDTH'(i_load_data) << (WIDTH - LOAD_W));
    end else begin
      w_next = w_base;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lane <= '0;
    end else begin
      r_lane <= w_next;
    end
  end

  assign w_tap_idx = TW'(i_tap);
  assign o_tap     = r_lane[w_tap_idx];
  assign o_lane    = r_lane;

endmodule

// File: rtl/ppu_tile_shifter.sv
// PPU background tile shifter: PLANES parallel shift lanes fed from a staging
// register, with auto (phase-wrap) or manual transfer and sticky error flags.
module ppu_tile_shifter
  import ppu_shift_pkg::*;
#(
  parameter int PLANES = DEF_PLANES,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOAD_W = DEF_LOAD_W,
  parameter int OW     = $clog2(LOAD_W)
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_shift,
  input  logic [PLANES-1:0]        i_fill,
  input  logic                     i_load_en,
  input  logic [PLANES*LOAD_W-1:0] i_load_data,
  input  logic                     i_auto,
  input  logic                     i_transfer,
  input  logic                     i_sync,
  input  logic [OW-1:0]            i_fine_x,
  input  logic                     i_clear_err,
  output logic [PLANES-1:0]        o_pixel,
  output logic [OW-1:0]            o_phase,
  output logic                     o_stage_full,
  output logic                     o_reload,
  output logic                     o_underrun,
  output logic                     o_overrun,
  output logic [PLANES*WIDTH-1:0]  o_debug_lanes
);

  logic [PLANES*LOAD_W-1:0] r_stage;
  logic                     r_stage_full;
  logic [OW-1:0]            r_phase;
  logic                     r_reload;
  logic                     r_underrun;
  logic                     r_overrun;

  logic w_phase_last;
  logic w_xfer_req;
  logic w_xfer_ok;
  logic w_underrun_set;
  logic w_overrun_set;

  assign w_phase_last   = (r_phase == OW'(LOAD_W - 1));
  assign w_xfer_req     = i_auto ? (i_shift && w_phase_last) : i_transfer;
  assign w_xfer_ok      = w_xfer_req && r_stage_full;
  assign w_underrun_set = w_xfer_req && !r_stage_full;
  // A load in the same cycle as a successful transfer refills rather than overwrites.
  assign w_overrun_set  = i_load_en && r_stage_full && !w_xfer_ok;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stage      <= '0;
      r_stage_full <= 1'b0;
      r_phase      <= '0;
      r_reload     <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_reload <= w_xfer_ok;
      if (i_load_en) begin
        r_stage      <= i_load_data;
        r_stage_full <= 1'b1;
      end else if (w_xfer_ok) begin
        r_stage_full <= 1'b0;
      end
      if (i_sync) begin
        r_phase <= '0;
      end else if (i_shift) begin
        r_phase <= w_phase_last ? '0 : r_phase + OW'(1);
      end
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end else if (i_clear_err) begin
        r_underrun <= 1'b0;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (i_clear_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < PLANES; p++) begin : g_lane
    shift_lane #(
      .WIDTH (WIDTH),
      .LOAD_W(LOAD_W),
      .OW    (OW)
    ) u_lane (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_shift    (i_shift),
      .i_fill     (i_fill[p]),
      .i_load     (w_xfer_ok),
      .i_load_data(r_stage[p*LOAD_W +: LOAD_W]),
      .i_tap      (i_fine_x),
      .o_tap      (o_pixel[p]),
      .o_lane     (o_debug_lanes[p*WIDTH +: WIDTH])
    );
  end

  assign o_phase      = r_phase;
  assign o_stage_full = r_stage_full;
  assign o_reload     = r_reload;
  assign o_underrun   = r_underrun;
  assign o_overrun    = r_overrun;

endmodule
